// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Brief    : Writeback-source / register-file port bundle for reg_write_arbiter
// Revision : 1.0
// ============================================================================
interface reg_write_arbiter_if;
    logic [3:0] req;
    logic       hold;
    logic [4:0] reg_dest;
    logic [1:0] key;
    logic       write_valid;
    logic       reg_write;
    logic [3:0] ack;
    logic       busy;
    logic       dropped;

    modport master (
        output req, hold, reg_dest,
        input  key, write_valid, reg_write, ack, busy, dropped
    );

    modport slave (
        input  req, hold, reg_dest,
        output key, write_valid, reg_write, ack, busy, dropped
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter for the shared register-file write port
// Revision : 1.0
// ============================================================================
module reg_write_arbiter (
    input  wire                  clock,
    input  wire                  reset,
    reg_write_arbiter_if.slave   bus
);

    logic [3:0] pending;
    logic [1:0] ptr;
    logic [1:0] key;
    logic       write_valid;
    logic [3:0] ack;
    logic       dropped;

    logic [1:0] winner;
    logic       found;
    logic       grant;
    logic [3:0] clear;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (pending[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
                found  = 1'b1;
            end
        end
    end

    assign grant = found & ~bus.hold;
    assign clear = grant ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending     <= 4'b0000;
            ptr         <= 2'd0;
            key         <= 2'd0;
            write_valid <= 1'b0;
            ack         <= 4'b0000;
            dropped     <= 1'b0;
        end else begin
            // A request landing on its own grant cycle re-arms the bit.
            pending <= (pending & ~clear) | bus.req;
            dropped <= dropped | (|(bus.req & pending & ~clear));
            if (grant) begin
                key         <= winner;
                write_valid <= 1'b1;
                ack         <= 4'b0001 << winner;
                ptr         <= winner + 2'd1;
            end else begin
                write_valid <= 1'b0;
                ack         <= 4'b0000;
            end
        end
    end

    assign bus.key         = key;
    assign bus.write_valid = write_valid;
    assign bus.ack         = ack;
    assign bus.busy        = |pending;
    assign bus.dropped     = dropped;
    assign bus.reg_write   = write_valid & (bus.reg_dest != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Directed and randomized checks of reg_write_arbiter against a model
// Revision : 1.0
// ============================================================================
module tb_reg_write_arbiter;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state: a set of outstanding sources plus a rotating start.
    bit m_pend [4];
    int m_ptr;
    int m_key;
    bit m_wv;
    int m_ack;
    bit m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_ptr = 0; m_key = 0; m_wv = 1'b0; m_ack = 0; m_drop = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic hd, input logic rs);
        int w;
        bit clr [4];
        if (!rs) begin
            model_reset();
            return;
        end
        w = -1;
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (m_ptr + i) % 4;
            if (w < 0 && m_pend[j]) w = j;
        end
        for (int i = 0; i < 4; i++) clr[i] = (!hd && w == i);
        for (int i = 0; i < 4; i++)
            if (rq[i] && m_pend[i] && !clr[i]) m_drop = 1'b1;
        if (!hd && w >= 0) begin
            m_key = w; m_wv = 1'b1; m_ack = 1 << w; m_ptr = (w + 1) % 4;
        end else begin
            m_wv = 1'b0; m_ack = 0;
        end
        for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] && !clr[i]) || rq[i];
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, check 1 ns later.
    task automatic cyc(input logic [3:0] rq, input logic hd, input logic [4:0] dst, input logic rs);
        bit any;
        @(negedge clock);
        bus.req = rq; bus.hold = hd; bus.reg_dest = dst; reset = rs;
        @(posedge clock);
        #1;
        model_step(rq, hd, rs);
        any = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
        check("key",         bus.key,         m_key);
        check("write_valid", bus.write_valid, m_wv);
        check("ack",         bus.ack,         m_ack);
        check("busy",        bus.busy,        any);
        check("dropped",     bus.dropped,     m_drop);
        check("reg_write",   bus.reg_write,   m_wv && (dst != 5'd0));
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        reset = 1'b0; bus.req = 4'b0; bus.hold = 1'b0; bus.reg_dest = 5'd0;
        model_reset();

        // Reset held with all requests asserted, then released with none.
        cyc(4'b1111, 1'b0, 5'd3, 1'b0);
        cyc(4'b1111, 1'b0, 5'd3, 1'b0);
        check("rst_wv", bus.write_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        cyc(4'b0000, 1'b0, 5'd3, 1'b1);
        cyc(4'b0000, 1'b0, 5'd3, 1'b1);
        check("post_rst_idle", bus.write_valid, 1'b0);

        // Single request from the load unit.
        cyc(4'b0010, 1'b0, 5'd7, 1'b1);
        check("single_busy", bus.busy, 1'b1);
        cyc(4'b0000, 1'b0, 5'd7, 1'b1);
        check("single_key", bus.key, 2'd1);
        check("single_ack", bus.ack, 4'b0010);
        cyc(4'b0000, 1'b0, 5'd7, 1'b1);
        check("single_idle", bus.write_valid, 1'b0);

        // Round robin from ptr=0 with all four sources.
        cyc(4'b0000, 1'b0, 5'd1, 1'b0);
        cyc(4'b1111, 1'b0, 5'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, 1'b0, 5'd1, 1'b1);
            check("rr_key", bus.key, k);
        end
        cyc(4'b1001, 1'b0, 5'd1, 1'b1);
        cyc(4'b0000, 1'b0, 5'd1, 1'b1);
        check("rr2_key_a", bus.key, 2'd0);
        cyc(4'b0000, 1'b0, 5'd1, 1'b1);
        check("rr2_key_b", bus.key, 2'd3);

        // Hold freezes a pending link write.
        cyc(4'b0100, 1'b0, 5'd9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0000, 1'b1, 5'd9, 1'b1);
            check("hold_wv", bus.write_valid, 1'b0);
        end
        cyc(4'b0000, 1'b0, 5'd9, 1'b1);
        check("hold_key", bus.key, 2'd2);

        // Writes to $zero are acknowledged but not performed.
        cyc(4'b0001, 1'b0, 5'd0, 1'b1);
        cyc(4'b0000, 1'b0, 5'd0, 1'b1);
        check("zero_ack", bus.ack, 4'b0001);
        check("zero_rw", bus.reg_write, 1'b0);
        cyc(4'b0001, 1'b0, 5'd5, 1'b1);
        cyc(4'b0000, 1'b0, 5'd5, 1'b1);
        check("nz_rw", bus.reg_write, 1'b1);

        // Duplicate request while pending is merged and flagged.
        cyc(4'b1000, 1'b1, 5'd2, 1'b1);
        cyc(4'b1000, 1'b1, 5'd2, 1'b1);
        check("dup_dropped", bus.dropped, 1'b1);
        cyc(4'b0000, 1'b0, 5'd2, 1'b1);
        cyc(4'b0000, 1'b0, 5'd2, 1'b1);
        check("dup_single", bus.write_valid, 1'b0);

        // Re-request on the grant edge is kept without a drop.
        cyc(4'b0000, 1'b0, 5'd2, 1'b0);
        cyc(4'b1000, 1'b0, 5'd2, 1'b1);
        cyc(4'b1000, 1'b0, 5'd2, 1'b1);
        check("rereq_dropped", bus.dropped, 1'b0);
        cyc(4'b0000, 1'b0, 5'd2, 1'b1);
        check("rereq_second", bus.write_valid, 1'b1);

        // Reset in the middle of a burst.
        cyc(4'b1110, 1'b0, 5'd4, 1'b1);
        cyc(4'b0000, 1'b0, 5'd4, 1'b1);
        cyc(4'b0000, 1'b0, 5'd4, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        cyc(4'b0000, 1'b0, 5'd4, 1'b1);
        cyc(4'b0000, 1'b0, 5'd4, 1'b1);
        check("midrst_idle", bus.write_valid, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rq;
            logic       hd;
            logic [4:0] dst;
            logic       rs;
            rq  = 4'($urandom) & 4'($urandom);
            hd  = ($urandom_range(0, 3) == 0);
            dst = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            rs  = ($urandom_range(0, 59) != 0);
            cyc(rq, hd, dst, rs);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
